gpmc_sdram_bridge: RTL and testbench
====================================

GPMC_SDRAM_BRIDGE -- requirements
Module: gpmc_sdram_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: GPMC register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: GPMC data width.
REQ-003 SHALL have parameter SD_ADDR_WIDTH, default 25, range 17..32: SDRAM word address width.
REQ-004 SHALL have parameter SD_DATA_WIDTH, default 8, range 1..16: SDRAM data width.
REQ-005 SHALL have parameter WFIFO_DEPTH, default 4, power of two, range 2..16: posted-write FIFO depth.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk, in, 1: sole clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- csn / wen / oen, in, 1 each: synchronised GPMC strobes, active-low.
- gpmc_addr, in, ADDR_WIDTH: register select.
- data_out, in, DATA_WIDTH: host write data.
- data_in, out, DATA_WIDTH: host read data.
- sd_addr, out, SD_ADDR_WIDTH: controller address.
- sd_wr_data, out, SD_DATA_WIDTH: controller write data.
- sd_wr_enable / sd_rd_enable, out, 1 each: command requests.
- sd_rd_data, in, SD_DATA_WIDTH: controller read data.
- sd_rd_ready / sd_busy / sd_ack, in, 1 each: controller status.
- sd_rst, out, 1: controller reset, active-high.

Function
REQ-007 SHALL accept exactly one host access per csn-low period: a write when !wen&&oen, a read when wen&&!oen; the access latch clears when csn is high.
REQ-008 Register 0 write SHALL behave as follows:
- bit15=1 queues a read request.
- bit13 loads sd_rst.
- bit0 loads AUTO_INC.
REQ-009 Register 0 read SHALL return:
- bit15 rd_pending; bit14 wr_busy (FIFO non-empty or write in flight); bit13 sd_rst; bit12 sd_busy.
- bit11 FIFO full; bit10 rd_valid; bit9 overflow (sticky); bit0 AUTO_INC; bits[7:4] FIFO count.
- All other bits 0.
REQ-010 Registers 1 and 2 SHALL read and write address bits [15:0] and [SD_ADDR_WIDTH-1:16] respectively; unused high bits read 0.
REQ-011 A register 3 write SHALL push {addr, data_out[SD_DATA_WIDTH-1:0]} into the FIFO and, when AUTO_INC=1, increment addr modulo 2^SD_ADDR_WIDTH.
REQ-012 A register 3 write while the FIFO is full SHALL be dropped, leave addr unchanged, and set overflow; overflow clears on a register 0 read.
REQ-013 A register 3 read SHALL return the zero-extended last read data and clear rd_valid.
REQ-014 Reads of unmapped registers SHALL return 0; writes to unmapped registers SHALL be ignored.
REQ-015 data_in SHALL update on the clock edge following access detection.
REQ-016 Dispatch FSM states SHALL be IDLE, WR_REQ, RD_REQ, RD_WAIT.
REQ-017 IDLE transitions:
- FIFO non-empty -> WR_REQ (FIFO head presented on sd_addr/sd_wr_data).
- Else rd_pending -> RD_REQ (sd_addr = addr captured at queue time).
- Writes have priority: a read is never issued while the FIFO is non-empty.
REQ-018 WR_REQ SHALL hold sd_wr_enable=1 until the cycle sd_ack=1, then pop the FIFO and return to IDLE.
REQ-019 RD_REQ SHALL hold sd_rd_enable=1 until sd_ack=1, then move to RD_WAIT.
REQ-020 On sd_rd_ready in RD_WAIT the block SHALL capture sd_rd_data, set rd_valid, clear rd_pending, go to IDLE, and increment addr if AUTO_INC=1.
REQ-021 A read request while rd_pending=1 SHALL be ignored.
REQ-022 A FIFO push and pop in the same cycle SHALL leave the count unchanged.
REQ-023 Minimum latency: a register 3 write detected at cycle N SHALL produce sd_wr_enable=1 at cycle N+2 when the FSM is idle and the FIFO is empty.
REQ-024 While sd_rst=1 the block SHALL:
- hold the FSM in IDLE and flush the FIFO;
- clear rd_pending and rd_valid;
- keep sd_wr_enable=0 and sd_rd_enable=0;
- continue to accept register accesses.

Reset
REQ-025 On rst_n=0, asynchronously:
- FSM=IDLE; FIFO empty; addr=0; AUTO_INC=0.
- sd_rst=0; rd_pending, rd_valid, overflow = 0; data_in=0.
- sd_addr=0, sd_wr_data=0, sd_wr_enable=0, sd_rd_enable=0.
REQ-026 Reset asserted mid-command SHALL abandon the command; no request output remains asserted after rst_n rises.

Configuration
REQ-027 With macro GPMC_SDRAM_PREFETCH_EN defined, a register 3 read SHALL also queue a read at the current addr (subject to REQ-021), giving streaming reads.
REQ-028 Without GPMC_SDRAM_PREFETCH_EN, reads SHALL be issued only via register 0 bit15, and the register 3 read path SHALL be as described in REQ-013 only.

Verification
REQ-029 Write reg1=0x0010, reg2=0, reg0=0x0001, then reg3 = 0xA5, 0x5A -> two writes, at sd_addr 0x10 and 0x11, each with sd_wr_enable held until sd_ack; final addr=0x12.
REQ-030 Stall sd_ack and issue WFIFO_DEPTH+1 writes to reg3 -> FIFO full flag set, the last write is dropped, overflow=1, and overflow clears after a reg0 read.
REQ-031 Queue 2 writes, then a read at 0x20 -> sd_rd_enable is not asserted until both writes are acked; the read returns 0x3C with rd_valid=1.
REQ-032 Set reg0 bit13 mid-WR_REQ -> sd_wr_enable drops next cycle and FIFO count=0; clearing bit13 resumes idle operation.
REQ-033 Assert rst_n=0 asynchronously mid-RD_WAIT -> all outputs reach reset values without a clock edge.
REQ-034 With GPMC_SDRAM_PREFETCH_EN, two consecutive reg3 reads from 0x40 -> reads issued at 0x40 and 0x41; without the macro, no read is issued.

Source files
------------

// File: rtl/gpmc_sdram_bridge.sv
// ---------------------------------------------------------------------------
// gpmc_sdram_bridge
//
// Bridges a synchronised GPMC host bus onto a simple SDRAM controller
// command interface. The host sees four 16-bit registers:
//   0 : control / status
//   1 : SDRAM word address [15:0]
//   2 : SDRAM word address [SD_ADDR_WIDTH-1:16]
//   3 : write = posted write to FIFO, read = last read data
// Posted writes go through a small FIFO and always drain before a queued
// read is issued to the controller.
//
// Optional feature: define GPMC_SDRAM_PREFETCH_EN to make every register 3
// read also queue a controller read at the current address (streaming reads).
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   csn, wen, oen             : GPMC strobes (active-low, already synchronised)
//   gpmc_addr, data_out       : register select and host write data
//   data_in                   : host read data (registered)
//   sd_addr, sd_wr_data       : controller command address / write data
//   sd_wr_enable, sd_rd_enable: controller command requests, held until sd_ack
//   sd_rd_data, sd_rd_ready   : controller read return
//   sd_busy, sd_ack           : controller status / command acknowledge
//   sd_rst                    : controller reset (active-high, from reg0 bit13)
//
// DATA_WIDTH is expected to be at least 16 (register map is 16 bits wide).
// ---------------------------------------------------------------------------
module gpmc_sdram_bridge #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SD_ADDR_WIDTH = 25,
    parameter int SD_DATA_WIDTH = 8,
    parameter int WFIFO_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     csn,
    input  logic                     wen,
    input  logic                     oen,
    input  logic [ADDR_WIDTH-1:0]    gpmc_addr,
    input  logic [DATA_WIDTH-1:0]    data_out,
    output logic [DATA_WIDTH-1:0]    data_in,
    output logic [SD_ADDR_WIDTH-1:0] sd_addr,
    output logic [SD_DATA_WIDTH-1:0] sd_wr_data,
    output logic                     sd_wr_enable,
    output logic                     sd_rd_enable,
    input  logic [SD_DATA_WIDTH-1:0] sd_rd_data,
    input  logic                     sd_rd_ready,
    input  logic                     sd_busy,
    input  logic                     sd_ack,
    output logic                     sd_rst
);

    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SD_ADDR_WIDTH-1:0] addr;
        logic [SD_DATA_WIDTH-1:0] data;
    } wentry_t;

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

    state_t                   state;
    logic [SD_ADDR_WIDTH-1:0] addr;
    logic [SD_ADDR_WIDTH-1:0] addr_nxt;
    logic [SD_ADDR_WIDTH-1:0] rd_addr;
    logic [SD_DATA_WIDTH-1:0] rd_data;
    logic                     auto_inc;
    logic                     rd_pending;
    logic                     rd_valid;
    logic                     overflow;

    // ---------------------------------------------------------------------
    // Host access detection: one access per csn-low period.
    // ---------------------------------------------------------------------
    logic acc_done, is_wr, is_rd, acc_go, host_wr, host_rd;
    logic sel0, sel1, sel2, sel3;
    logic wr0, wr1, wr2, wr3, rd0, rd3;
    logic [15:0] wd;

    assign is_wr   = !wen && oen;
    assign is_rd   = wen && !oen;
    assign acc_go  = !csn && !acc_done && (is_wr || is_rd);
    assign host_wr = acc_go && is_wr;
    assign host_rd = acc_go && is_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc_done <= 1'b0;
        else if (csn)    acc_done <= 1'b0;
        else if (acc_go) acc_done <= 1'b1;
    end

    assign sel0 = (gpmc_addr == ADDR_WIDTH'(0));
    assign sel1 = (gpmc_addr == ADDR_WIDTH'(1));
    assign sel2 = (gpmc_addr == ADDR_WIDTH'(2));
    assign sel3 = (gpmc_addr == ADDR_WIDTH'(3));
    assign wr0  = host_wr && sel0;
    assign wr1  = host_wr && sel1;
    assign wr2  = host_wr && sel2;
    assign wr3  = host_wr && sel3;
    assign rd0  = host_rd && sel0;
    assign rd3  = host_rd && sel3;
    assign wd   = data_out[15:0];

    // Flush acts in the same cycle as the reg0 write that raises sd_rst so
    // an in-flight request drops on the very edge sd_rst goes high.
    logic flush;
    assign flush = sd_rst || (wr0 && wd[13]);

    // ---------------------------------------------------------------------
    // Posted-write FIFO
    // ---------------------------------------------------------------------
    wentry_t          mem [WFIFO_DEPTH];
    wentry_t          head;
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;
    logic             fifo_full, fifo_empty, push_ok, push, pop;

    assign fifo_full  = (cnt == CNT_W'(WFIFO_DEPTH));
    assign fifo_empty = (cnt == '0);
    assign head       = mem[rptr];
    // push_ok governs addr/overflow bookkeeping; the entry itself is
    // discarded while the FIFO is being flushed.
    assign push_ok    = wr3 && !fifo_full;
    assign push       = push_ok && !flush;
    assign pop        = (state == WR_REQ) && sd_ack && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{addr: addr, data: wd[SD_DATA_WIDTH-1:0]};
    end

    // ---------------------------------------------------------------------
    // Read queueing
    // ---------------------------------------------------------------------
    logic rd_req_src, rd_queue, rd_done;

`ifdef GPMC_SDRAM_PREFETCH_EN
    assign rd_req_src = (wr0 && wd[15]) || rd3;
`else
    assign rd_req_src = wr0 && wd[15];
`endif

    // A request while one is already pending is dropped.
    assign rd_queue = rd_req_src && !rd_pending && !flush;
    assign rd_done  = (state == RD_WAIT) && sd_rd_ready && !flush;

    // ---------------------------------------------------------------------
    // Address register: host writes plus auto-increment on accepted
    // posted writes and on completed reads.
    // ---------------------------------------------------------------------
    always_comb begin
        addr_nxt = addr;
        if (wr1) addr_nxt[15:0] = wd;
        if (wr2) addr_nxt[SD_ADDR_WIDTH-1:16] = wd[SD_ADDR_WIDTH-17:0];
        if (auto_inc && push_ok) addr_nxt = addr_nxt + SD_ADDR_WIDTH'(1);
        if (auto_inc && rd_done) addr_nxt = addr_nxt + SD_ADDR_WIDTH'(1);
    end

    // ---------------------------------------------------------------------
    // Host read mux
    // ---------------------------------------------------------------------
    logic [15:0] rd_word;
    logic        wr_busy;

    assign wr_busy = !fifo_empty || (state == WR_REQ);

    always_comb begin
        rd_word = '0;
        if (sel0) begin
            rd_word[15]  = rd_pending;
            rd_word[14]  = wr_busy;
            rd_word[13]  = sd_rst;
            rd_word[12]  = sd_busy;
            rd_word[11]  = fifo_full;
            rd_word[10]  = rd_valid;
            rd_word[9]   = overflow;
            rd_word[7:4] = 4'(cnt);
            rd_word[0]   = auto_inc;
        end else if (sel1) begin
            rd_word = addr[15:0];
        end else if (sel2) begin
            rd_word[SD_ADDR_WIDTH-17:0] = addr[SD_ADDR_WIDTH-1:16];
        end else if (sel3) begin
            rd_word[SD_DATA_WIDTH-1:0] = rd_data;
        end
    end

    // ---------------------------------------------------------------------
    // Control / status registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            auto_inc   <= 1'b0;
            sd_rst     <= 1'b0;
            rd_pending <= 1'b0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
            data_in    <= '0;
        end else begin
            addr <= addr_nxt;
            if (wr0) begin
                sd_rst   <= wd[13];
                auto_inc <= wd[0];
            end

            if (wr3 && fifo_full) overflow <= 1'b1;
            else if (rd0)         overflow <= 1'b0;

            if (flush) begin
                rd_pending <= 1'b0;
                rd_valid   <= 1'b0;
            end else begin
                if (rd_queue) begin
                    rd_pending <= 1'b1;
                    rd_addr    <= addr;
                end else if (rd_done) begin
                    rd_pending <= 1'b0;
                end
                // Fresh data wins over a simultaneous host consume.
                if (rd_done) begin
                    rd_valid <= 1'b1;
                    rd_data  <= sd_rd_data;
                end else if (rd3) begin
                    rd_valid <= 1'b0;
                end
            end

            if (host_rd) data_in <= DATA_WIDTH'(rd_word);
        end
    end

    // ---------------------------------------------------------------------
    // Dispatch FSM: writes drain first, then a pending read.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sd_addr      <= '0;
            sd_wr_data   <= '0;
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            sd_wr_enable <= 1'b0;
            sd_rd_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state        <= WR_REQ;
                        sd_addr      <= head.addr;
                        sd_wr_data   <= head.data;
                        sd_wr_enable <= 1'b1;
                    end else if (rd_pending) begin
                        state        <= RD_REQ;
                        sd_addr      <= rd_addr;
                        sd_rd_enable <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (sd_ack) begin
                        state        <= IDLE;
                        sd_wr_enable <= 1'b0;
                    end
                end
                RD_REQ: begin
                    if (sd_ack) begin
                        state        <= RD_WAIT;
                        sd_rd_enable <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (sd_rd_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpmc_sdram_bridge.sv
// ---------------------------------------------------------------------------
// tb_gpmc_sdram_bridge
//
// Directed bench for gpmc_sdram_bridge (default parameters). A table of
// register accesses covers reset values and the register map; hand-written
// sequences cover posted writes, FIFO overflow, write-before-read ordering,
// sd_rst flush, asynchronous reset and the optional prefetch path.
// ---------------------------------------------------------------------------
module tb_gpmc_sdram_bridge;

    logic        clk;
    logic        rst_n;
    logic        csn, wen, oen;
    logic [3:0]  gpmc_addr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic [24:0] sd_addr;
    logic [7:0]  sd_wr_data;
    logic        sd_wr_enable, sd_rd_enable;
    logic [7:0]  sd_rd_data;
    logic        sd_rd_ready, sd_busy, sd_ack;
    logic        sd_rst;

    int n_total = 0;
    int n_pass  = 0;

    gpmc_sdram_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csn          (csn),
        .wen          (wen),
        .oen          (oen),
        .gpmc_addr    (gpmc_addr),
        .data_out     (data_out),
        .data_in      (data_in),
        .sd_addr      (sd_addr),
        .sd_wr_data   (sd_wr_data),
        .sd_wr_enable (sd_wr_enable),
        .sd_rd_enable (sd_rd_enable),
        .sd_rd_data   (sd_rd_data),
        .sd_rd_ready  (sd_rd_ready),
        .sd_busy      (sd_busy),
        .sd_ack       (sd_ack),
        .sd_rst       (sd_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        gpmc_addr = a; data_out = d; csn = 1'b0; wen = 1'b0; oen = 1'b1;
        repeat (hold) @(negedge clk);
        csn = 1'b1; wen = 1'b1; oen = 1'b1;
    endtask

    task automatic host_read(input logic [3:0] a, output logic [15:0] d);
        @(negedge clk);
        gpmc_addr = a; csn = 1'b0; wen = 1'b1; oen = 1'b0;
        @(negedge clk);
        d = data_in;
        csn = 1'b1; wen = 1'b1; oen = 1'b1;
    endtask

    task automatic read_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] d;
        host_read(a, d);
        chk(name, 32'(d), 32'(exp));
    endtask

    // Wait for a write request, check it, hold ack low for 'stall' cycles,
    // then ack and check the request drops.
    task automatic wait_wr(input logic [24:0] ea, input logic [7:0] ed, input int stall);
        int n = 0;
        while (!sd_wr_enable && n < 50) begin @(negedge clk); n++; end
        chk("wr_seen", 32'(sd_wr_enable), 32'd1);
        chk("wr_addr", 32'(sd_addr), 32'(ea));
        chk("wr_data", 32'(sd_wr_data), 32'(ed));
        chk("wr_no_rd", 32'(sd_rd_enable), 32'd0);
        repeat (stall) begin
            @(negedge clk);
            chk("wr_hold", 32'(sd_wr_enable), 32'd1);
            chk("wr_hold_no_rd", 32'(sd_rd_enable), 32'd0);
        end
        sd_ack = 1'b1;
        @(negedge clk);
        sd_ack = 1'b0;
        chk("wr_drop", 32'(sd_wr_enable), 32'd0);
    endtask

    task automatic wait_rd(input logic [24:0] ea, input logic [7:0] d, input int stall, input bit give_ready);
        int n = 0;
        while (!sd_rd_enable && n < 50) begin @(negedge clk); n++; end
        chk("rd_seen", 32'(sd_rd_enable), 32'd1);
        chk("rd_addr", 32'(sd_addr), 32'(ea));
        chk("rd_no_wr", 32'(sd_wr_enable), 32'd0);
        repeat (stall) begin
            @(negedge clk);
            chk("rd_hold", 32'(sd_rd_enable), 32'd1);
        end
        sd_ack = 1'b1;
        @(negedge clk);
        sd_ack = 1'b0;
        chk("rd_drop", 32'(sd_rd_enable), 32'd0);
        if (give_ready) begin
            @(negedge clk);
            sd_rd_data = d; sd_rd_ready = 1'b1;
            @(negedge clk);
            sd_rd_ready = 1'b0;
        end
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  a;
        logic [15:0] d;
        bit          busy;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [15];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        int seen;

        rst_n = 1'b0; csn = 1'b1; wen = 1'b1; oen = 1'b1;
        gpmc_addr = '0; data_out = '0; sd_rd_data = '0;
        sd_rd_ready = 1'b0; sd_busy = 1'b0; sd_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(sd_wr_enable), 32'd0);
        chk("rst_rd_en", 32'(sd_rd_enable), 32'd0);
        chk("rst_sd_addr", 32'(sd_addr), 32'd0);
        chk("rst_sd_rst", 32'(sd_rst), 32'd0);
        chk("rst_data_in", 32'(data_in), 32'd0);
        rst_n = 1'b1;

        // Register map vectors: {wr, reg, wdata, sd_busy, expected read}
        vt[0]  = '{0, 4'd0,  16'h0000, 0, 16'h0000};
        vt[1]  = '{0, 4'd1,  16'h0000, 0, 16'h0000};
        vt[2]  = '{0, 4'd2,  16'h0000, 0, 16'h0000};
        vt[3]  = '{0, 4'd3,  16'h0000, 0, 16'h0000};
        vt[4]  = '{1, 4'd1,  16'hBEEF, 0, 16'h0000};
        vt[5]  = '{0, 4'd1,  16'h0000, 0, 16'hBEEF};
        vt[6]  = '{1, 4'd2,  16'hFFFF, 0, 16'h0000};
        vt[7]  = '{0, 4'd2,  16'h0000, 0, 16'h01FF};
        vt[8]  = '{1, 4'd5,  16'h1234, 0, 16'h0000};
        vt[9]  = '{0, 4'd5,  16'h0000, 0, 16'h0000};
        vt[10] = '{1, 4'd0,  16'h0001, 0, 16'h0000};
        vt[11] = '{0, 4'd0,  16'h0000, 0, 16'h0001};
        vt[12] = '{0, 4'd0,  16'h0000, 1, 16'h1001};
        vt[13] = '{1, 4'd0,  16'h0000, 0, 16'h0000};
        vt[14] = '{0, 4'd15, 16'h0000, 0, 16'h0000};

        for (int i = 0; i < 15; i++) begin
            sd_busy = vt[i].busy;
            if (vt[i].wr) host_write(vt[i].a, vt[i].d, 1);
            else          read_chk($sformatf("vec%0d", i), vt[i].a, vt[i].exp);
        end
        sd_busy = 1'b0;

        // Two posted writes with auto-increment, plus minimum latency.
        host_write(4'd1, 16'h0010, 1);
        host_write(4'd2, 16'h0000, 1);
        host_write(4'd0, 16'h0001, 1);
        host_write(4'd3, 16'h00A5, 1);
        chk("lat_n1", 32'(sd_wr_enable), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(sd_wr_enable), 32'd1);
        wait_wr(25'h10, 8'hA5, 2);
        host_write(4'd3, 16'h005A, 3);   // csn held low: still one access
        wait_wr(25'h11, 8'h5A, 1);
        repeat (3) @(negedge clk);
        chk("single_acc", 32'(sd_wr_enable), 32'd0);
        read_chk("addr_after_wr", 4'd1, 16'h0012);
        read_chk("st_idle", 4'd0, 16'h0001);

        // FIFO overflow with ack stalled.
        host_write(4'd3, 16'h0011, 1);
        host_write(4'd3, 16'h0022, 1);
        host_write(4'd3, 16'h0033, 1);
        host_write(4'd3, 16'h0044, 1);
        host_write(4'd3, 16'h0055, 1);
        read_chk("ovf_status", 4'd0, 16'h4A41);
        read_chk("ovf_cleared", 4'd0, 16'h4841);
        read_chk("ovf_addr", 4'd1, 16'h0016);
        wait_wr(25'h12, 8'h11, 0);
        wait_wr(25'h13, 8'h22, 0);
        wait_wr(25'h14, 8'h33, 0);
        wait_wr(25'h15, 8'h44, 0);
        repeat (3) @(negedge clk);
        chk("ovf_dropped", 32'(sd_wr_enable), 32'd0);
        read_chk("ovf_drained", 4'd0, 16'h0001);

        // Writes drain before a queued read.
        host_write(4'd3, 16'h0077, 1);
        host_write(4'd3, 16'h0088, 1);
        host_write(4'd1, 16'h0020, 1);
        host_write(4'd0, 16'h8001, 1);
        wait_wr(25'h16, 8'h77, 2);
        wait_wr(25'h17, 8'h88, 2);
        wait_rd(25'h20, 8'h3C, 2, 1'b1);
        read_chk("rd_status", 4'd0, 16'h0401);
        read_chk("rd_data", 4'd3, 16'h003C);
        read_chk("rd_valid_clr", 4'd0, 16'h0001);
        read_chk("rd_addr_inc", 4'd1, 16'h0021);

        // sd_rst during WR_REQ flushes and drops the request.
        host_write(4'd3, 16'h0099, 1);
        seen = 0;
        while (!sd_wr_enable && seen < 20) begin @(negedge clk); seen++; end
        chk("flush_pre", 32'(sd_wr_enable), 32'd1);
        host_write(4'd0, 16'h2001, 1);
        chk("flush_sd_rst", 32'(sd_rst), 32'd1);
        chk("flush_wr_drop", 32'(sd_wr_enable), 32'd0);
        read_chk("flush_status", 4'd0, 16'h2001);
        host_write(4'd0, 16'h0001, 1);
        chk("flush_release", 32'(sd_rst), 32'd0);
        host_write(4'd3, 16'h0066, 1);
        wait_wr(25'h22, 8'h66, 0);

        // Asynchronous reset while in RD_WAIT.
        read_chk("pre_rst_addr", 4'd1, 16'h0023);
        host_write(4'd0, 16'h8001, 1);
        wait_rd(25'h23, 8'h00, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sd_addr", 32'(sd_addr), 32'd0);
        chk("arst_wr_data", 32'(sd_wr_data), 32'd0);
        chk("arst_rd_en", 32'(sd_rd_enable), 32'd0);
        chk("arst_wr_en", 32'(sd_wr_enable), 32'd0);
        chk("arst_data_in", 32'(data_in), 32'd0);
        chk("arst_sd_rst", 32'(sd_rst), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (sd_rd_enable || sd_wr_enable) seen++;
        end
        chk("post_rst_idle", 32'(seen), 32'd0);
        read_chk("post_rst_status", 4'd0, 16'h0000);

        // Streaming reads through register 3.
        host_write(4'd1, 16'h0040, 1);
        host_write(4'd2, 16'h0000, 1);
        host_write(4'd0, 16'h0001, 1);
`ifdef GPMC_SDRAM_PREFETCH_EN
        read_chk("pf_first", 4'd3, 16'h0000);
        wait_rd(25'h40, 8'hC1, 0, 1'b1);
        read_chk("pf_data0", 4'd3, 16'h00C1);
        wait_rd(25'h41, 8'hC2, 0, 1'b1);
        read_chk("pf_status", 4'd0, 16'h0401);
`else
        read_chk("nopf_rd0", 4'd3, 16'h0000);
        read_chk("nopf_rd1", 4'd3, 16'h0000);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sd_rd_enable) seen++;
        end
        chk("nopf_no_read", 32'(seen), 32'd0);
        read_chk("nopf_status", 4'd0, 16'h0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
